pll_lock_sequencer: RTL and testbench

- Controller on the other end of a PLL wrapper's reset/lock interface. It drives the PLL `rst` input, consumes the asynchronous `locked` output, and produces a clean core reset for logic clocked by the PLL outputs.
- It pulses the PLL reset, waits for a stable lock with a timeout, retries a bounded number of times, and re-sequences on loss of lock.
- Clocked by the PLL reference clock (e.g. 74.25 MHz), so it runs before any PLL output clock exists.

---
 rtl/pll_lock_sequencer.sv | 159 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer.
// Pulses the PLL reset, waits for a stable synchronized lock within a timeout,
// retries a bounded number of times, and re-sequences on loss of lock.
// Runs entirely on the PLL reference clock, so it works before any PLL output
// clock exists. All outputs are registered from the next-state value, so they
// change on the same edge as the state register and cannot glitch.
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       lock_ok,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  // Shared counter covers both the reset pulse and the lock timeout.
  localparam int unsigned CNT_MAX = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST    = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAIL      = 2'd3
  } state_t;

  // state_q is kept as a plainly named register so checkers can bind to it.
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [3:0]    retry_d;
  logic [7:0]    loss_d;
  logic          pll_rst_d, core_rst_d, lock_ok_d, fail_d;
  logic          sync1_q, sync2_q;
  logic          lock_s;

  assign lock_s = sync2_q;

  // Two-flop synchronizer for the asynchronous PLL locked signal.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      stab_q      <= '0;
      retry_count <= 4'd0;
      loss_count  <= 8'd0;
      pll_rst     <= 1'b1;
      core_rst    <= 1'b1;
      lock_ok     <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      retry_count <= retry_d;
      loss_count  <= loss_d;
      pll_rst     <= pll_rst_d;
      core_rst    <= core_rst_d;
      lock_ok     <= lock_ok_d;
      fail        <= fail_d;
    end
  end

  // Next-state, counter updates and output decode from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stab_d  = stab_q;
    retry_d = retry_count;
    loss_d  = loss_count;

    if (relock_req) begin
      // Restart request overrides everything; held high it keeps the pulse
      // counter cleared so the pulse starts once the request drops.
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      stab_d  = '0;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            stab_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          cnt_d  = cnt_q + 1'b1;
          stab_d = lock_s ? (stab_q + 1'b1) : '0;
          // Stable lock is tested first so it wins over a coincident timeout.
          if (lock_s && (stab_q == STAB_LAST)) begin
            state_d = ST_RUN;
            retry_d = 4'd0;
            cnt_d   = '0;
            stab_d  = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_count + 4'd1;
            cnt_d   = '0;
            stab_d  = '0;
            state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            if (loss_count != 8'hff) begin
              loss_d = loss_count + 8'd1;
            end
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
          stab_d  = '0;
        end
      endcase
    end

    pll_rst_d  = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
    core_rst_d = (state_d != ST_RUN);
    lock_ok_d  = (state_d == ST_RUN);
    fail_d     = (state_d == ST_FAIL);
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small parameters
// (pulse 4, timeout 100, stable 8, max retries 2).
// Inputs change and outputs are checked just after the falling edge; the
// expected cycle numbers are counted in rising edges since the reference point
// named in each step.
module tb_pll_lock_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       core_rst;
  logic       lock_ok;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  int checks   = 0;
  int failures = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(100),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .core_rst   (core_rst),
    .lock_ok    (lock_ok),
    .fail       (fail),
    .retry_count(retry_count),
    .loss_count (loss_count)
  );

  // Clock: 10 ns period, rising edges at 10, 20, ...
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    step(2);

    // Reset values while rst is held.
    chk("rst_pll_rst",  8'(pll_rst), 8'd1);
    chk("rst_core_rst", 8'(core_rst), 8'd1);
    chk("rst_lock_ok",  8'(lock_ok), 8'd0);
    chk("rst_fail",     8'(fail), 8'd0);
    chk("rst_retry",    8'(retry_count), 8'd0);
    chk("rst_loss",     8'(loss_count), 8'd0);

    // ---- 1: clean bring-up, lock arrives 10 cycles into WAIT_LOCK ----
    rst = 1'b0;                                   // N=0
    chk("t1_pll_rst_n0", 8'(pll_rst), 8'd1);
    step(3);                                      // N=3
    chk("t1_pll_rst_n3", 8'(pll_rst), 8'd1);
    step(1);                                      // N=4, WAIT_LOCK
    chk("t1_pll_rst_n4", 8'(pll_rst), 8'd0);
    chk("t1_core_rst_n4", 8'(core_rst), 8'd1);
    step(10);                                     // N=14
    pll_locked = 1'b1;
    step(9);                                      // N=23
    chk("t1_lock_ok_n23", 8'(lock_ok), 8'd0);
    chk("t1_core_rst_n23", 8'(core_rst), 8'd1);
    step(1);                                      // N=24 = 4+10+2+8
    chk("t1_lock_ok_n24", 8'(lock_ok), 8'd1);
    chk("t1_core_rst_n24", 8'(core_rst), 8'd0);
    chk("t1_retry", 8'(retry_count), 8'd0);

    // ---- 2: one-cycle lock dropout restarts the stability count ----
    pll_locked = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;                                   // N=0
    step(4);                                      // N=4, WAIT_LOCK
    pll_locked = 1'b1;
    step(5);                                      // N=9
    pll_locked = 1'b0;
    step(1);                                      // N=10
    pll_locked = 1'b1;
    step(4);                                      // N=14: would be RUN without the dropout
    chk("t2_lock_ok_n14", 8'(lock_ok), 8'd0);
    step(5);                                      // N=19
    chk("t2_lock_ok_n19", 8'(lock_ok), 8'd0);
    step(1);                                      // N=20
    chk("t2_lock_ok_n20", 8'(lock_ok), 8'd1);
    chk("t2_retry", 8'(retry_count), 8'd0);

    // ---- 3: no lock -> two timeouts -> FAIL, then relock_req ----
    pll_locked = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;                                   // N=0
    step(103);                                    // N=103
    chk("t3_pll_rst_n103", 8'(pll_rst), 8'd0);
    step(1);                                      // N=104, first timeout
    chk("t3_pll_rst_n104", 8'(pll_rst), 8'd1);
    chk("t3_retry_n104", 8'(retry_count), 8'd1);
    step(3);                                      // N=107
    chk("t3_pll_rst_n107", 8'(pll_rst), 8'd1);
    step(1);                                      // N=108
    chk("t3_pll_rst_n108", 8'(pll_rst), 8'd0);
    step(99);                                     // N=207
    chk("t3_fail_n207", 8'(fail), 8'd0);
    step(1);                                      // N=208, second timeout
    chk("t3_fail_n208", 8'(fail), 8'd1);
    chk("t3_pll_rst_n208", 8'(pll_rst), 8'd1);
    chk("t3_core_rst_n208", 8'(core_rst), 8'd1);
    chk("t3_retry_n208", 8'(retry_count), 8'd2);
    step(20);
    chk("t3_fail_held", 8'(fail), 8'd1);
    chk("t3_pll_rst_held", 8'(pll_rst), 8'd1);
    relock_req = 1'b1;
    step(1);                                      // R=0
    relock_req = 1'b0;
    chk("t3_fail_relock", 8'(fail), 8'd0);
    chk("t3_retry_relock", 8'(retry_count), 8'd0);
    chk("t3_pll_rst_r0", 8'(pll_rst), 8'd1);
    step(3);                                      // R=3
    chk("t3_pll_rst_r3", 8'(pll_rst), 8'd1);
    step(1);                                      // R=4, WAIT_LOCK
    chk("t3_pll_rst_r4", 8'(pll_rst), 8'd0);
    pll_locked = 1'b1;
    step(9);                                      // R=13
    chk("t3_lock_ok_r13", 8'(lock_ok), 8'd0);
    step(1);                                      // R=14
    chk("t3_lock_ok_r14", 8'(lock_ok), 8'd1);

    // ---- 4: loss of lock in RUN, then saturation of loss_count ----
    pll_locked = 1'b0;                            // M=0
    step(1);
    pll_locked = 1'b1;                            // M=1
    step(1);                                      // M=2
    chk("t4_lock_ok_m2", 8'(lock_ok), 8'd1);
    step(1);                                      // M=3
    chk("t4_lock_ok_m3", 8'(lock_ok), 8'd0);
    chk("t4_core_rst_m3", 8'(core_rst), 8'd1);
    chk("t4_pll_rst_m3", 8'(pll_rst), 8'd1);
    chk("t4_loss_m3", 8'(loss_count), 8'd1);
    chk("t4_retry_m3", 8'(retry_count), 8'd0);
    step(3);                                      // M=6
    chk("t4_pll_rst_m6", 8'(pll_rst), 8'd1);
    step(1);                                      // M=7
    chk("t4_pll_rst_m7", 8'(pll_rst), 8'd0);
    step(7);                                      // M=14
    chk("t4_lock_ok_m14", 8'(lock_ok), 8'd0);
    step(1);                                      // M=15
    chk("t4_lock_ok_m15", 8'(lock_ok), 8'd1);
    for (int i = 2; i <= 300; i++) begin
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(14);
      chk($sformatf("t4_loss_%0d", i), loss_count, (i > 255) ? 8'd255 : 8'(i));
    end
    chk("t4_lock_ok_end", 8'(lock_ok), 8'd1);

    // ---- 5: relock_req in RUN, in WAIT_LOCK, and on a timeout edge ----
    relock_req = 1'b1;
    step(1);                                      // R=0
    relock_req = 1'b0;
    chk("t5_run_lock_ok", 8'(lock_ok), 8'd0);
    chk("t5_run_pll_rst", 8'(pll_rst), 8'd1);
    chk("t5_run_core_rst", 8'(core_rst), 8'd1);
    chk("t5_run_retry", 8'(retry_count), 8'd0);
    chk("t5_run_loss", 8'(loss_count), 8'd255);
    step(4);                                      // R=4, WAIT_LOCK
    chk("t5_wait_pll_rst", 8'(pll_rst), 8'd0);
    step(2);                                      // R=6
    relock_req = 1'b1;
    pll_locked = 1'b0;
    step(1);                                      // S=0
    relock_req = 1'b0;
    chk("t5_wait_relock_pll_rst", 8'(pll_rst), 8'd1);
    chk("t5_wait_relock_lock_ok", 8'(lock_ok), 8'd0);
    chk("t5_wait_relock_retry", 8'(retry_count), 8'd0);
    step(104);                                    // S=104, first timeout
    chk("t5_retry_s104", 8'(retry_count), 8'd1);
    chk("t5_pll_rst_s104", 8'(pll_rst), 8'd1);
    step(103);                                    // S=207
    chk("t5_retry_s207", 8'(retry_count), 8'd1);
    chk("t5_pll_rst_s207", 8'(pll_rst), 8'd0);
    relock_req = 1'b1;                            // coincides with second timeout
    step(1);                                      // S=208
    relock_req = 1'b0;
    chk("t5_coinc_retry", 8'(retry_count), 8'd0);
    chk("t5_coinc_fail", 8'(fail), 8'd0);
    chk("t5_coinc_pll_rst", 8'(pll_rst), 8'd1);
    chk("t5_coinc_loss", 8'(loss_count), 8'd255);

    // ---- 6: short asynchronous reset during WAIT_LOCK ----
    step(10);                                     // in WAIT_LOCK
    chk("t6_pre_pll_rst", 8'(pll_rst), 8'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_pll_rst", 8'(pll_rst), 8'd1);
    chk("t6_async_core_rst", 8'(core_rst), 8'd1);
    chk("t6_async_lock_ok", 8'(lock_ok), 8'd0);
    chk("t6_async_fail", 8'(fail), 8'd0);
    chk("t6_async_retry", 8'(retry_count), 8'd0);
    chk("t6_async_loss", 8'(loss_count), 8'd0);
    #1;
    rst = 1'b0;
    pll_locked = 1'b1;
    step(1);                                      // N=1
    chk("t6_pll_rst_n1", 8'(pll_rst), 8'd1);
    step(2);                                      // N=3
    chk("t6_pll_rst_n3", 8'(pll_rst), 8'd1);
    step(1);                                      // N=4
    chk("t6_pll_rst_n4", 8'(pll_rst), 8'd0);
    step(7);                                      // N=11
    chk("t6_lock_ok_n11", 8'(lock_ok), 8'd0);
    step(1);                                      // N=12
    chk("t6_lock_ok_n12", 8'(lock_ok), 8'd1);
    chk("t6_core_rst_n12", 8'(core_rst), 8'd0);
    chk("t6_loss_n12", 8'(loss_count), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
